// File: rtl/fixed_point_pkg.sv
// Shared fixed-point helpers: Q-format widths, saturation constants and
// the default Q4.29 datapath constants.
package fixed_point_pkg;

   localparam int unsigned SAT_MAX_W = 128;

   typedef logic [SAT_MAX_W-1:0] sat_word_t;

   function automatic int unsigned total_w(input int unsigned d, input int unsigned f);
      return d + f;
   endfunction

   function automatic int unsigned prod_w(input int unsigned d, input int unsigned f);
      return 2 * (d + f);
   endfunction

   // Callers truncate these to the target width w.
   function automatic sat_word_t sat_max(input int unsigned w);
      return (sat_word_t'(1) << (w - 1)) - sat_word_t'(1);
   endfunction

   function automatic sat_word_t sat_min(input int unsigned w);
      return sat_word_t'(1) << (w - 1);
   endfunction

   localparam int unsigned          Q4_29_W    = 33;
   localparam logic [Q4_29_W-1:0]   Q4_29_ONE  = Q4_29_W'(1) << 29;
   localparam logic [Q4_29_W-1:0]   Q4_29_FOUR = Q4_29_W'(4) << 29;

endpackage

// File: rtl/fxp_saturate.sv
// Clamp a wide two's-complement value into OUT_W bits, flagging overflow.
// Purely combinational so adders and multipliers can share it.
module fxp_saturate
   import fixed_point_pkg::*;
#(
   parameter int unsigned IN_W  = 66,
   parameter int unsigned OUT_W = 33
) (
   input  logic [IN_W-1:0]  val_i,
   output logic [OUT_W-1:0] sat_c_o,
   output logic             ovf_c_o
);

   localparam int unsigned HI_W = IN_W - OUT_W + 1;

   if (OUT_W < 1 || OUT_W > IN_W || OUT_W > SAT_MAX_W) begin : g_bad_cfg
      $error("fxp_saturate: illegal width parameters");
   end

   logic [HI_W-1:0] hi;
   logic            fits;

   // Value fits when every bit from the target sign bit upward agrees.
   assign hi   = val_i[IN_W-1:OUT_W-1];
   assign fits = (&hi) | ~(|hi);

   always_comb begin
      sat_c_o = val_i[OUT_W-1:0];
      ovf_c_o = 1'b0;
      if (!fits) begin
         ovf_c_o = 1'b1;
         sat_c_o = val_i[IN_W-1] ? OUT_W'(sat_min(OUT_W)) : OUT_W'(sat_max(OUT_W));
      end
   end

endmodule

// File: rtl/signed_fixed_point_mult.sv
// Two-stage signed fixed-point multiplier: Q(iD).(iF) x Q(iD).(iF) -> Q(oD).(oF),
// floor truncation and saturation, one operand pair per clock.
module signed_fixed_point_mult
   import fixed_point_pkg::*;
#(
   parameter int unsigned iD = 4,
   parameter int unsigned iF = 29,
   parameter int unsigned oD = 4,
   parameter int unsigned oF = 29
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         in_valid,
   input  logic [total_w(iD, iF)-1:0]   A,
   input  logic [total_w(iD, iF)-1:0]   B,
   output logic                         out_valid,
   output logic [total_w(oD, oF)-1:0]   O,
   output logic                         ovf
);

   localparam int unsigned PW = prod_w(iD, iF);
   localparam int unsigned OW = total_w(oD, oF);
   localparam int unsigned SH = 2 * iF - oF;

   if (iD < 1 || oD < 1 || oF > 2 * iF || oD > 2 * iD || OW > SAT_MAX_W) begin : g_bad_cfg
      $error("signed_fixed_point_mult: illegal Q-format parameters");
   end

   logic signed [PW-1:0] prod_d, prod_q;
   logic                 vld1_q;
   logic signed [PW-1:0] aligned;
   logic [OW-1:0]        sat_val;
   logic                 sat_ovf;
   logic [OW-1:0]        o_d, o_q;
   logic                 ovf_d, ovf_q;
   logic                 vld2_q;

   // Full-precision signed product, left to synthesis for DSP mapping.
   always_comb prod_d = PW'($signed(A)) * PW'($signed(B));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         prod_q <= '0;
         vld1_q <= 1'b0;
      end else begin
         vld1_q <= in_valid;
         if (in_valid) prod_q <= prod_d;
      end
   end

   // Arithmetic shift drops the low fraction bits, i.e. rounds toward -inf.
   always_comb aligned = prod_q >>> SH;

   fxp_saturate #(
      .IN_W  (PW),
      .OUT_W (OW)
   ) u_sat (
      .val_i   (aligned),
      .sat_c_o (sat_val),
      .ovf_c_o (sat_ovf)
   );

   always_comb begin
      o_d   = o_q;
      ovf_d = ovf_q;
      if (vld1_q) begin
         o_d   = sat_val;
         ovf_d = sat_ovf;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         o_q    <= '0;
         ovf_q  <= 1'b0;
         vld2_q <= 1'b0;
      end else begin
         o_q    <= o_d;
         ovf_q  <= ovf_d;
         vld2_q <= vld1_q;
      end
   end

   assign out_valid = vld2_q;
   assign O         = o_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_signed_fixed_point_mult.sv
// Scoreboarded bench for signed_fixed_point_mult: default Q4.29 instance plus
// a Q13.29 -> Q4.29 format-conversion instance sharing clock and reset.
module tb_signed_fixed_point_mult;

   typedef struct {
      logic [32:0] o;
      logic        ovf;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;

   logic        m_in_valid = 1'b0;
   logic [32:0] m_a = '0, m_b = '0;
   logic        m_out_valid;
   logic [32:0] m_o;
   logic        m_ovf;

   logic        c_in_valid = 1'b0;
   logic [41:0] c_a = '0, c_b = '0;
   logic        c_out_valid;
   logic [32:0] c_o;
   logic        c_ovf;

   exp_t mq[$];
   exp_t cq[$];
   exp_t me, ce;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   signed_fixed_point_mult #(.iD(4), .iF(29), .oD(4), .oF(29)) u_main (
      .CLK(CLK), .RST_N(RST_N), .in_valid(m_in_valid), .A(m_a), .B(m_b),
      .out_valid(m_out_valid), .O(m_o), .ovf(m_ovf)
   );

   signed_fixed_point_mult #(.iD(13), .iF(29), .oD(4), .oF(29)) u_conv (
      .CLK(CLK), .RST_N(RST_N), .in_valid(c_in_valid), .A(c_a), .B(c_b),
      .out_valid(c_out_valid), .O(c_o), .ovf(c_ovf)
   );

   // Reference: exact product, floor shift, compare against the output range.
   function automatic exp_t model(input logic signed [127:0] a, input logic signed [127:0] b,
                                  input int ifr);
      logic signed [127:0] p, r, mx, mn;
      exp_t e;
      p  = a * b;
      r  = p >>> (2 * ifr - 29);
      mx = (128'sd1 <<< 32) - 128'sd1;
      mn = -(128'sd1 <<< 32);
      e.ovf = 1'b0;
      if (r > mx) begin
         e.o = 33'(mx); e.ovf = 1'b1;
      end else if (r < mn) begin
         e.o = 33'(mn); e.ovf = 1'b1;
      end else begin
         e.o = 33'(r);
      end
      return e;
   endfunction

   // Scoreboard pop side: each out_valid pulse consumes the oldest expectation.
   always @(negedge CLK) begin
      if (m_out_valid === 1'b1) begin
         n_tests++;
         if (mq.size() == 0) begin
            n_fail++;
            $display("FAIL main_unexpected: out_valid=1 O=%h with nothing pending", m_o);
         end else begin
            me = mq.pop_front();
            if (m_o !== me.o || m_ovf !== me.ovf) begin
               n_fail++;
               $display("FAIL main_result: got O=%h ovf=%b, expected O=%h ovf=%b", m_o, m_ovf, me.o, me.ovf);
            end
         end
      end
      if (c_out_valid === 1'b1) begin
         n_tests++;
         if (cq.size() == 0) begin
            n_fail++;
            $display("FAIL conv_unexpected: out_valid=1 O=%h with nothing pending", c_o);
         end else begin
            ce = cq.pop_front();
            if (c_o !== ce.o || c_ovf !== ce.ovf) begin
               n_fail++;
               $display("FAIL conv_result: got O=%h ovf=%b, expected O=%h ovf=%b", c_o, c_ovf, ce.o, ce.ovf);
            end
         end
      end
   end

   task automatic drive_m(input logic [32:0] a, input logic [32:0] b,
                          input logic [32:0] eo, input logic eovf);
      exp_t e;
      @(negedge CLK);
      m_in_valid = 1'b1; m_a = a; m_b = b;
      e.o = eo; e.ovf = eovf;
      mq.push_back(e);
   endtask

   task automatic drive_c(input logic [41:0] a, input logic [41:0] b,
                          input logic [32:0] eo, input logic eovf);
      exp_t e;
      @(negedge CLK);
      c_in_valid = 1'b1; c_a = a; c_b = b;
      e.o = eo; e.ovf = eovf;
      cq.push_back(e);
   endtask

   // Idle the inputs until both scoreboards empty or the budget runs out.
   task automatic drain();
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         m_in_valid = 1'b0; c_in_valid = 1'b0;
         if (i >= 3 && mq.size() == 0 && cq.size() == 0) break;
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      n_tests++;
      if (m_out_valid !== 1'b0 || m_o !== 33'd0 || m_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_main: out_valid=%b O=%h ovf=%b, expected 0/0/0", m_out_valid, m_o, m_ovf);
      end
      n_tests++;
      if (c_out_valid !== 1'b0 || c_o !== 33'd0 || c_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_conv: out_valid=%b O=%h ovf=%b, expected 0/0/0", c_out_valid, c_o, c_ovf);
      end
      RST_N = 1'b1;
   endtask

   task automatic test_basic();
      drive_m(33'h0_3000_0000, 33'h0_4000_0000, 33'h0_6000_0000, 1'b0); //  1.5 *  2.0
      drive_m(33'h1_D000_0000, 33'h0_4000_0000, 33'h1_A000_0000, 1'b0); // -1.5 *  2.0
      drive_m(33'h1_8000_0000, 33'h0_4000_0000, 33'h1_0000_0000, 1'b0); // -4.0 *  2.0 = min
      drive_m(33'h0_4000_0000, 33'h0_4000_0000, 33'h0_8000_0000, 1'b0); //  2.0 *  2.0
      drain();
      n_tests++;
      if (mq.size() != 0) begin
         n_fail++;
         $display("FAIL basic_drain: %0d results pending, expected 0", mq.size());
      end
   endtask

   task automatic test_saturation();
      drive_m(33'h0_6000_0000, 33'h0_6000_0000, 33'h0_FFFF_FFFF, 1'b1); //  3 *  3
      drive_m(33'h1_8000_0000, 33'h1_8000_0000, 33'h0_FFFF_FFFF, 1'b1); // -4 * -4
      drive_m(33'h1_8000_0000, 33'h0_6000_0000, 33'h1_0000_0000, 1'b1); // -4 *  3
      drain();
      n_tests++;
      if (mq.size() != 0) begin
         n_fail++;
         $display("FAIL sat_drain: %0d results pending, expected 0", mq.size());
      end
   endtask

   task automatic test_truncation();
      drive_m(33'h0_0000_0001, 33'h0_0000_0001, 33'h0_0000_0000, 1'b0);
      drive_m(33'h1_FFFF_FFFF, 33'h0_0000_0001, 33'h1_FFFF_FFFF, 1'b0);
      drive_m(33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 33'h0_0000_0000, 1'b0);
      drain();
      n_tests++;
      if (mq.size() != 0) begin
         n_fail++;
         $display("FAIL trunc_drain: %0d results pending, expected 0", mq.size());
      end
   endtask

   task automatic test_format_conversion();
      logic [41:0] s12, s3;
      s12 = 42'd1 << 17;  // 2^-12 in Q13.29
      s3  = 42'd1 << 26;  // 2^-3
      drive_c(s12, 42'd100 << 29, 33'h0_00C8_0000, 1'b0);
      drive_c(s12, -(42'd1000 << 29), 33'(-(64'sd1000 <<< 17)), 1'b0);
      drive_c(s3, 42'd100 << 29, 33'h0_FFFF_FFFF, 1'b1);
      drive_c(s3, -(42'd100 << 29), 33'h1_0000_0000, 1'b1);
      drive_c(s3, -(42'd64 << 29), 33'h1_0000_0000, 1'b0);
      drive_c(s3, 42'd63 << 29, 33'h0_FC00_0000, 1'b0);
      drain();
      n_tests++;
      if (cq.size() != 0) begin
         n_fail++;
         $display("FAIL conv_drain: %0d results pending, expected 0", cq.size());
      end
   endtask

   task automatic test_back_to_back();
      bit   pat [14] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
      bit   h1 = 1'b0, h2 = 1'b0;
      logic [32:0] a, b;
      exp_t e;
      for (int i = 0; i < 14; i++) begin
         @(negedge CLK);
         n_tests++;
         if (m_out_valid !== h2) begin
            n_fail++;
            $display("FAIL b2b_valid cycle %0d: out_valid=%b, expected %b", i, m_out_valid, h2);
         end
         if (pat[i]) begin
            a = 33'({$urandom, $urandom}) >>> 3;
            b = 33'({$urandom, $urandom}) >>> 3;
            m_a = a; m_b = b; m_in_valid = 1'b1;
            e = model(128'($signed(a)), 128'($signed(b)), 29);
            mq.push_back(e);
         end else begin
            m_in_valid = 1'b0;
         end
         h2 = h1; h1 = pat[i];
      end
      drain();
      n_tests++;
      if (mq.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain: %0d results pending, expected 0", mq.size());
      end
   endtask

   task automatic test_random();
      logic [32:0] a, b;
      exp_t e;
      for (int i = 0; i < 40; i++) begin
         a = 33'({$urandom, $urandom});
         b = 33'({$urandom, $urandom});
         a = 33'($signed(a) >>> $urandom_range(0, 8));
         b = 33'($signed(b) >>> $urandom_range(0, 8));
         e = model(128'($signed(a)), 128'($signed(b)), 29);
         drive_m(a, b, e.o, e.ovf);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge CLK);
            m_in_valid = 1'b0;
         end
      end
      drain();
      n_tests++;
      if (mq.size() != 0) begin
         n_fail++;
         $display("FAIL random_drain: %0d results pending, expected 0", mq.size());
      end
   endtask

   task automatic test_reset_flush();
      int   pulses;
      exp_t e;
      drive_m(33'h0_3000_0000, 33'h0_4000_0000, 33'h0_6000_0000, 1'b0);
      drive_m(33'h1_D000_0000, 33'h0_4000_0000, 33'h1_A000_0000, 1'b0);
      @(posedge CLK);
      #2;
      n_tests++;
      if (m_out_valid !== 1'b1 || m_o !== 33'h0_6000_0000) begin
         n_fail++;
         $display("FAIL flush_pre: out_valid=%b O=%h, expected 1/000060000000", m_out_valid, m_o);
      end
      RST_N = 1'b0;
      #1;
      n_tests++;
      if (m_out_valid !== 1'b0 || m_o !== 33'd0 || m_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_async: out_valid=%b O=%h ovf=%b, expected 0/0/0", m_out_valid, m_o, m_ovf);
      end
      mq.delete();
      m_in_valid = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      // New operands presented on the very first edge after release.
      RST_N = 1'b1;
      m_in_valid = 1'b1; m_a = 33'h1_8000_0000; m_b = 33'h0_6000_0000;
      e.o = 33'h1_0000_0000; e.ovf = 1'b1;
      mq.push_back(e);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         m_in_valid = 1'b0;
         if (m_out_valid === 1'b1) pulses++;
      end
      n_tests++;
      if (pulses != 1 || mq.size() != 0) begin
         n_fail++;
         $display("FAIL flush_after: %0d pulses, %0d pending, expected 1 pulse 0 pending", pulses, mq.size());
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_basic();
      test_saturation();
      test_truncation();
      test_format_conversion();
      test_back_to_back();
      test_random();
      test_reset_flush();
      drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
